alu_issue_stage: RTL and testbench

//   Decode/issue stage directly upstream of the ALU. Accepts 32-bit instruction words on a valid/ready

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_if.sv | 8 +
 rtl/alu_cond_eval.sv | 36 +++
 rtl/alu_issue_stage.sv | 102 ++++++++++
 tb/tb_alu_issue_stage.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: instruction field layout, condition codes and flag positions for the issue stage
package alu_issue_pkg;
  localparam int NREGS = 16;
  localparam int RW = $clog2(NREGS);
  localparam int COND_LO = 28;
  localparam int OPC_LO = 24;
  localparam int S_BIT = 23;
  localparam int I_BIT = 22;
  localparam int RD_LO = 18;
  localparam int RN_LO = 14;
  localparam int RM_LO = 10;
  localparam int SRC_LO = 7;
  localparam int SRB_LO = 2;
  localparam int IMM_W = 14;
  localparam logic [3:0] OPC_CMP = 4'b1011;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [3:0] {
    COND_AL, COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS,
    COND_VC, COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_NV
  } cond_e;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction valid/ready handshake into the issue stage
interface alu_issue_if;
  logic instr_valid;
  logic instr_ready;
  logic [31:0] instr;
  modport master(output instr_valid, instr, input instr_ready);
  modport slave(input instr_valid, instr, output instr_ready);
endinterface

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: evaluates a 4-bit condition code against NZCV flags
module alu_cond_eval
  import alu_issue_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];
  // condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_AL: pass = 1'b1;
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue stage feeding the ALU; define ALU_ISSUE_FWD_EN for operand forwarding instead of interlock
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_if.slave      ib,
  input  logic            hold,
  output logic [RW-1:0]   rf_raddr1,
  output logic [RW-1:0]   rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] In1,
  output logic [XLEN-1:0] In2,
  output logic [3:0]      Opcode,
  output logic [3:0]      Cond,
  output logic            S,
  output logic [2:0]      SR_Cont,
  output logic [4:0]      SR_Bit,
  output logic [15:0]     Immediate,
  input  logic [XLEN-1:0] Out,
  input  logic [3:0]      Flags,
  output logic            ex_valid,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic [3:0]      flags_q
);
  logic d_valid, s_q, pass, writes_d, accept, interlock, i_in, unused;
  logic d_n, d_m, w_n, w_m;
  logic [3:0] cond_q;
  logic [RW-1:0] rd_q, rn, rm;
  logic [XLEN-1:0] op1, op2;
  assign rn = ib.instr[RN_LO +: RW];
  assign rm = ib.instr[RM_LO +: RW];
  assign i_in = ib.instr[I_BIT];
  assign unused = ^ib.instr[1:0];
  assign rf_raddr1 = rn;
  assign rf_raddr2 = rm;
  alu_cond_eval u_cond (.cond(cond_q), .nzcv(flags_q), .pass(pass));
  assign ex_valid = d_valid & pass;
  assign writes_d = ex_valid & (Opcode != OPC_CMP);
  assign S = s_q & ex_valid;
  assign Cond = 4'b0000;
  assign d_n = writes_d && rd_q == rn;
  assign d_m = writes_d && rd_q == rm;
  assign w_n = wb_valid && wb_addr == rn;
  assign w_m = wb_valid && wb_addr == rm;
`ifdef ALU_ISSUE_FWD_EN
  assign op1 = d_n ? Out : w_n ? wb_data : rf_rdata1;
  assign op2 = d_m ? Out : w_m ? wb_data : rf_rdata2;
  assign interlock = 1'b0;
`else
  assign op1 = rf_rdata1;
  assign op2 = rf_rdata2;
  assign interlock = ib.instr_valid && (d_n || w_n || (!i_in && (d_m || w_m)));
`endif
  assign ib.instr_ready = ~rst & ~hold & ~interlock;
  assign accept = ib.instr_valid & ib.instr_ready;
  // D stage: capture accepted instruction, bubble when nothing accepted, freeze on hold
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_valid <= 1'b0;
      In1 <= '0;
      In2 <= '0;
      Opcode <= '0;
      cond_q <= '0;
      s_q <= 1'b0;
      rd_q <= '0;
      SR_Cont <= '0;
      SR_Bit <= '0;
      Immediate <= '0;
    end else if (!hold) begin
      d_valid <= accept;
      if (accept) begin
        In1 <= op1;
        In2 <= i_in ? XLEN'(ib.instr[IMM_W-1:0]) : op2;
        Opcode <= ib.instr[OPC_LO +: 4];
        cond_q <= ib.instr[COND_LO +: 4];
        s_q <= ib.instr[S_BIT];
        rd_q <= ib.instr[RD_LO +: RW];
        SR_Cont <= ib.instr[SRC_LO +: 3];
        SR_Bit <= ib.instr[SRB_LO +: 5];
        Immediate <= i_in ? {2'b00, ib.instr[IMM_W-1:0]} : 16'h0;
      end
    end
  // retire the D instruction into the writeback register and architectural flags
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flags_q <= '0;
    end else if (!hold) begin
      wb_valid <= writes_d;
      wb_addr <= rd_q;
      wb_data <= Out;
      if (ex_valid && s_q) flags_q <= Flags;
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against an in-order architectural model
module tb_alu_issue_stage;
`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {
    bit v, pass, s, wb;
    logic [3:0] op, rd, fl;
    logic [31:0] in1, in2, res;
    logic [15:0] imm;
    logic [2:0] src;
    logic [4:0] sb;
  } rec_t;

  logic clk = 1'b0, rst, hold;
  logic [3:0] rf_raddr1, rf_raddr2, Opcode, Cond, Flags, wb_addr, flags_q;
  logic [31:0] rf_rdata1, rf_rdata2, In1, In2, Out, wb_data;
  logic S, ex_valid, wb_valid;
  logic [2:0] SR_Cont;
  logic [4:0] SR_Bit;
  logic [15:0] Immediate;
  logic [31:0] rf [16];
  logic [31:0] mrf [16];
  logic [3:0] mflags, eflags;
  rec_t md, mw;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;
  alu_issue_if ib();
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .ib(ib), .hold(hold),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .In1(In1), .In2(In2), .Opcode(Opcode), .Cond(Cond), .S(S), .SR_Cont(SR_Cont), .SR_Bit(SR_Bit),
    .Immediate(Immediate), .Out(Out), .Flags(Flags), .ex_valid(ex_valid), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .flags_q(flags_q)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1: return 32'd15;
      2: return 32'd20;
      5, 6: return 32'd5;
      default: return 32'(i) * 32'h0001_0001;
    endcase
  endfunction

  // ALU: ADD=4, SUB=2, CMP=B (subtract, C = no borrow), AND=0, EOR=1, ORR=C, others pass b
  function automatic logic [35:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'h4: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h2, 4'hB: begin r = a - b; c = a >= b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h0: r = a & b;
      4'h1: r = a ^ b;
      4'hC: r = a | b;
      default: r = b;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return cy;
      4'd4: return !cy;
      4'd5: return n;
      4'd6: return !n;
      4'd7: return v;
      4'd8: return !v;
      4'd9: return cy && !z;
      4'd10: return !cy || z;
      4'd11: return n == v;
      4'd12: return n != v;
      4'd13: return !z && n == v;
      4'd14: return z || n != v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] op, input logic s, input logic i,
                                     input logic [3:0] rd, input logic [3:0] rn, input logic [13:0] lo);
    return {c, op, s, i, rd, rn, lo};
  endfunction

  function automatic logic [31:0] rop(input logic [3:0] c, input logic [3:0] op, input logic s,
                                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm);
    return mk(c, op, s, 1'b0, rd, rn, {rm, 10'd0});
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [3:0] ops [7];
    ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'hB, 4'hC, 4'hD};
    return mk($urandom_range(1) == 0 ? 4'd0 : 4'($urandom_range(15)), ops[$urandom_range(6)],
              1'($urandom_range(1)), $urandom_range(3) == 0, 4'($urandom_range(15)),
              4'($urandom_range(15)), 14'($urandom));
  endfunction

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always_comb {Flags, Out} = alu(Opcode, In1, In2);
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
    else if (wb_valid) rf[wb_addr] <= wb_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // architectural execution of one accepted instruction, in program order
  task automatic build(input logic [31:0] w, output rec_t r);
    logic [35:0] a;
    r.v = 1'b1;
    r.op = w[27:24];
    r.rd = w[21:18];
    r.s = w[23];
    r.in1 = mrf[w[17:14]];
    r.in2 = w[22] ? {18'd0, w[13:0]} : mrf[w[13:10]];
    r.imm = w[22] ? {2'b00, w[13:0]} : 16'h0;
    r.src = w[9:7];
    r.sb = w[6:2];
    r.pass = cond_ok(w[31:28], mflags);
    a = alu(r.op, r.in1, r.in2);
    r.fl = a[35:32];
    r.res = a[31:0];
    r.wb = r.pass && r.op != 4'hB;
    if (r.pass && r.s) mflags = r.fl;
    if (r.wb) mrf[r.rd] = r.res;
  endtask

  task automatic model_reset();
    md.v = 1'b0;
    mw.v = 1'b0;
    mflags = 4'h0;
    eflags = 4'h0;
    for (int i = 0; i < 16; i++) mrf[i] = init_val(i);
  endtask

  // a register is still pending while its writer has not yet reached the register file
  function automatic bit pend(input logic [3:0] r);
    return (md.v && md.wb && md.rd == r) || (mw.v && mw.wb && mw.rd == r);
  endfunction

  task automatic compare_all();
    chk("ex_valid", ex_valid, md.v && md.pass);
    chk("S", S, md.v && md.pass && md.s);
    chk("Cond", Cond, 0);
    if (md.v) begin
      chk("In1", In1, md.in1);
      chk("In2", In2, md.in2);
      chk("Opcode", Opcode, md.op);
      chk("Immediate", Immediate, md.imm);
      chk("SR_Cont", SR_Cont, md.src);
      chk("SR_Bit", SR_Bit, md.sb);
    end
    chk("wb_valid", wb_valid, mw.v && mw.wb);
    if (mw.v && mw.wb) begin
      chk("wb_addr", wb_addr, mw.rd);
      chk("wb_data", wb_data, mw.res);
    end
    chk("flags_q", flags_q, eflags);
  endtask

  // one cycle: check outputs, drive inputs, check ready, advance the model across the clock edge
  task automatic step(input logic v, input logic [31:0] w, input logic h, output logic acc);
    logic er;
    compare_all();
    ib.instr_valid = v;
    ib.instr = w;
    hold = h;
    #1;
    er = !h && !(!FWD && v && (pend(w[17:14]) || (!w[22] && pend(w[13:10]))));
    chk("instr_ready", ib.instr_ready, er);
    acc = v && ib.instr_ready;
    if (!h) begin
      if (md.v && md.pass && md.s) eflags = md.fl;
      mw = md;
      if (acc) build(w, md);
      else md.v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic zero_chk();
    chk("rst_ready", ib.instr_ready, 0);
    chk("rst_In1", In1, 0);
    chk("rst_In2", In2, 0);
    chk("rst_Opcode", Opcode, 0);
    chk("rst_Cond", Cond, 0);
    chk("rst_S", S, 0);
    chk("rst_SR", {SR_Cont, SR_Bit}, 0);
    chk("rst_Immediate", Immediate, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb", {wb_addr, wb_data}, 0);
    chk("rst_flags_q", flags_q, 0);
  endtask

  task automatic random_run(input int n);
    logic cv, acc;
    logic [31:0] cur;
    cv = 1'b0;
    acc = 1'b1;
    cur = 32'd0;
    for (int k = 0; k < n; k++) begin
      if (acc || !cv) begin
        cv = $urandom_range(3) != 0;
        cur = rand_instr();
      end
      step(cv, cur, $urandom_range(6) == 0, acc);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic acc;
    int stalls;
    rst = 1'b1;
    hold = 1'b0;
    ib.instr_valid = 1'b0;
    ib.instr = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    zero_chk();
    rst = 1'b0;
    // CMP 15,20 sets N; following EQ ADD is squashed
    step(1, rop(4'd0, 4'hB, 1, 4'd0, 4'd1, 4'd2), 0, acc);
    step(1, rop(4'd1, 4'h4, 0, 4'd3, 4'd1, 4'd2), 0, acc);
    chk("t2_flags", flags_q, 4'b1000);
    chk("t2_ex_valid", ex_valid, 0);
    step(0, 32'd0, 0, acc);
    chk("t2_wb_valid", wb_valid, 0);
    // CMP 5,5: NE squashed, EQ passes
    step(1, rop(4'd0, 4'hB, 1, 4'd0, 4'd5, 4'd6), 0, acc);
    step(1, rop(4'd2, 4'h4, 0, 4'd7, 4'd1, 4'd2), 0, acc);
    chk("t3_flags", flags_q, 4'b0110);
    chk("t3_ne_ex_valid", ex_valid, 0);
    step(1, rop(4'd1, 4'h4, 0, 4'd8, 4'd1, 4'd2), 0, acc);
    chk("t3_eq_ex_valid", ex_valid, 1);
    chk("t3_ne_wb_valid", wb_valid, 0);
    step(0, 32'd0, 0, acc);
    chk("t3_eq_wb_valid", wb_valid, 1);
    chk("t3_eq_wb_addr", wb_addr, 8);
    chk("t3_eq_wb_data", wb_data, 35);
    step(0, 32'd0, 0, acc);
    // ADD R3=R1+R2 then dependent SUB R4=R3-R1
    step(1, rop(4'd0, 4'h4, 0, 4'd3, 4'd1, 4'd2), 0, acc);
    stalls = 0;
    acc = 1'b0;
    for (int k = 0; k < 8 && !acc; k++) begin
      step(1, rop(4'd0, 4'h2, 0, 4'd4, 4'd3, 4'd1), 0, acc);
      if (!acc) stalls++;
    end
    chk("t4_accepted", acc, 1);
    chk("t4_stall_cycles", stalls, FWD ? 0 : 2);
    chk("t4_In1", In1, 35);
    chk("t4_In2", In2, 15);
    // immediate operand
    step(1, mk(4'd0, 4'h4, 0, 1, 4'd9, 4'd0, 14'h3FFF), 0, acc);
    chk("t5_In2", In2, 32'h0000_3FFF);
    chk("t5_Immediate", Immediate, 16'h3FFF);
    chk("t5_In1", In1, 0);
    // hold for three cycles with an instruction waiting
    step(0, 32'd0, 0, acc);
    step(0, 32'd0, 0, acc);
    step(1, rop(4'd0, 4'h4, 0, 4'd10, 4'd1, 4'd2), 0, acc);
    step(1, rop(4'd0, 4'h4, 0, 4'd12, 4'd5, 4'd6), 0, acc);
    for (int k = 0; k < 3; k++) begin
      step(1, rop(4'd0, 4'h2, 0, 4'd11, 4'd2, 4'd1), 1, acc);
      chk("t6_ready", ib.instr_ready, 0);
      chk("t6_In1", In1, 5);
      chk("t6_wb_valid", wb_valid, 1);
      chk("t6_wb_addr", wb_addr, 10);
      chk("t6_wb_data", wb_data, 35);
      chk("t6_flags", flags_q, 4'b0110);
    end
    step(1, rop(4'd0, 4'h2, 0, 4'd11, 4'd2, 4'd1), 0, acc);
    chk("t6_released", acc, 1);
    chk("t6_In1_after", In1, 20);
    chk("t6_In2_after", In2, 15);
    random_run(3000);
    // reset in mid-stream with a valid instruction offered
    rst = 1'b1;
    ib.instr_valid = 1'b1;
    ib.instr = rand_instr();
    #1;
    zero_chk();
    @(negedge clk);
    zero_chk();
    rst = 1'b0;
    model_reset();
    random_run(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
